// File: rtl/c16_snd_voices_if.sv
// Register-write strobe from the c16 core into the sound block.
interface c16_snd_voices_if;
  logic        snd_wen;
  logic [1:0]  w_param;
  logic [10:0] w_index;
  logic [15:0] w_val;

  modport master (output snd_wen, w_param, w_index, w_val);
  modport slave  (input  snd_wen, w_param, w_index, w_val);
endinterface

// File: rtl/c16_snd_voices.sv
// Four-voice square-wave tone generator with per-voice volume and duration,
// driven by the core's register-write strobe; emits a registered 8-bit mix.

// One voice: period/volume/duration registers, tone counter and phase.
module c16_snd_voice (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        ms,
  input  logic        wr_en,
  input  logic [1:0]  w_param,
  input  logic [15:0] w_val,
  output logic        active,
  output logic [5:0]  level
);
  logic [15:0] period_q, period_d, dur_q, dur_d, rem_q, rem_d, cnt_q, cnt_d;
  logic [3:0]  vol_q, vol_d;
  logic        phase_q, phase_d, active_q, active_d;

  // Next state: tone and duration first, then a register write overrides.
  always_comb begin
    period_d = period_q;
    vol_d    = vol_q;
    dur_d    = dur_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    active_d = active_q;
    if (active_q) begin
      if (period_q == 16'd0) begin
        cnt_d = 16'd0;
      end else if (tick) begin
        // >= so a period shortened mid-tone wraps on the next tick
        if (cnt_q >= period_q - 16'd1) begin
          cnt_d   = 16'd0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      if (ms && rem_q != 16'd0) begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) active_d = 1'b0;
      end
    end
    if (wr_en) begin
      case (w_param)
        2'd0: period_d = w_val;
        2'd1: vol_d    = w_val[3:0];
        2'd2: dur_d    = w_val;
        default: begin
          if (w_val[1]) begin
            active_d = 1'b0;
          end else if (w_val[0]) begin
            active_d = 1'b1;
            rem_d    = dur_q;
            cnt_d    = 16'd0;
            phase_d  = 1'b0;
          end
        end
      endcase
    end
  end

  // Voice state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      vol_q    <= '0;
      dur_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      period_q <= period_d;
      vol_q    <= vol_d;
      dur_q    <= dur_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;
  assign level  = (active_q && phase_q && period_q != 16'd0) ? {vol_q, 2'b00} : 6'd0;
endmodule

module c16_snd_voices #(
  parameter int TICK_DIV = 50,
  parameter int MS_TICKS = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  c16_snd_voices_if.slave         bus,
  output logic [7:0]              audio,
  output logic [3:0]              voice_active
);
  localparam int NUM_LANES = 4;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [MW-1:0] ms_cnt_q, ms_cnt_d;
  logic [7:0]    audio_q, audio_d;
  logic          tick, ms, wr_ok;
  logic [NUM_LANES-1:0]      wr_hit, active;
  logic [NUM_LANES-1:0][5:0] level;

  assign tick  = (presc_q == PW'(TICK_DIV - 1));
  assign ms    = tick && (ms_cnt_q == MW'(MS_TICKS - 1));
  assign wr_ok = bus.snd_wen && (bus.w_index[10:2] == 9'd0);

  // Free-running tone prescaler and millisecond counter.
  always_comb begin
    presc_d  = tick ? '0 : presc_q + PW'(1);
    ms_cnt_d = ms_cnt_q;
    if (tick) ms_cnt_d = ms ? '0 : ms_cnt_q + MW'(1);
  end

  for (genvar v = 0; v < NUM_LANES; v++) begin : g_voice
    assign wr_hit[v] = wr_ok && (bus.w_index[1:0] == 2'(v));
    c16_snd_voice u_voice (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .ms      (ms),
      .wr_en   (wr_hit[v]),
      .w_param (bus.w_param),
      .w_val   (bus.w_val),
      .active  (active[v]),
      .level   (level[v])
    );
  end

  // Mix: plain sum, 4 x 60 fits in 8 bits.
  always_comb begin
    audio_d = 8'd0;
    for (int v = 0; v < NUM_LANES; v++) audio_d = audio_d + 8'(level[v]);
  end

  // Timebase and output sample registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      ms_cnt_q <= '0;
      audio_q  <= '0;
    end else begin
      presc_q  <= presc_d;
      ms_cnt_q <= ms_cnt_d;
      audio_q  <= audio_d;
    end
  end

  assign audio        = audio_q;
  assign voice_active = active;
endmodule

// File: tb/tb_c16_snd_voices.sv
// Self-checking bench for c16_snd_voices with a per-edge behavioural model.
module tb_c16_snd_voices;
  localparam int TD = 2;
  localparam int MS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] audio;
  logic [3:0] voice_active;
  int checks = 0;
  int errors = 0;

  c16_snd_voices_if snd_if ();

  c16_snd_voices #(.TICK_DIV(TD), .MS_TICKS(MS)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (snd_if),
    .audio        (audio),
    .voice_active (voice_active)
  );

  always #5 clk = ~clk;

  // Reference model state, plain integers.
  int m_period[4], m_vol[4], m_dur[4], m_rem[4], m_cnt[4];
  bit m_phase[4], m_act[4];
  int m_audio;
  int edge_n;

  function automatic void model_reset();
    for (int v = 0; v < 4; v++) begin
      m_period[v] = 0; m_vol[v] = 0; m_dur[v] = 0; m_rem[v] = 0;
      m_cnt[v] = 0; m_phase[v] = 0; m_act[v] = 0;
    end
    m_audio = 0;
    edge_n  = 0;
  endfunction

  function automatic bit next_is_ms();
    return (edge_n % TD == TD - 1) && ((edge_n / TD) % MS == MS - 1);
  endfunction

  function automatic void model_edge(input bit wen, input int p, input int idx, input int val);
    int  mix;
    bit  tk, msk;
    mix = 0;
    for (int v = 0; v < 4; v++)
      if (m_act[v] && m_phase[v] && m_period[v] != 0) mix += m_vol[v] * 4;
    tk  = (edge_n % TD) == TD - 1;
    msk = next_is_ms();
    for (int v = 0; v < 4; v++) begin
      if (m_act[v]) begin
        if (m_period[v] == 0) m_cnt[v] = 0;
        else if (tk) begin
          if (m_cnt[v] + 1 >= m_period[v]) begin m_cnt[v] = 0; m_phase[v] = !m_phase[v]; end
          else m_cnt[v]++;
        end
        if (msk && m_rem[v] != 0) begin
          m_rem[v]--;
          if (m_rem[v] == 0) m_act[v] = 0;
        end
      end
    end
    if (wen && idx < 4) begin
      case (p)
        0: m_period[idx] = val & 16'hFFFF;
        1: m_vol[idx]    = val & 15;
        2: m_dur[idx]    = val & 16'hFFFF;
        default: begin
          if (val & 2) m_act[idx] = 0;
          else if (val & 1) begin
            m_act[idx] = 1; m_rem[idx] = m_dur[idx]; m_cnt[idx] = 0; m_phase[idx] = 0;
          end
        end
      endcase
    end
    edge_n++;
    m_audio = mix;
  endfunction

  function automatic logic [3:0] m_va();
    logic [3:0] r;
    for (int v = 0; v < 4; v++) r[v] = m_act[v];
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One clock edge with an optional register write; compares against the model.
  task automatic cyc(input bit wen, input int p, input int idx, input int val);
    snd_if.snd_wen = wen;
    snd_if.w_param = 2'(p);
    snd_if.w_index = 11'(idx);
    snd_if.w_val   = 16'(val);
    @(posedge clk);
    model_edge(wen, p, idx, val);
    #1;
    chk("audio", int'(audio), m_audio);
    chk("voice_active", int'(voice_active), int'(m_va()));
    snd_if.snd_wen = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic wr(input int p, input int idx, input int val);
    cyc(1, p, idx, val);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("reset_audio", int'(audio), 0);
    chk("reset_va", int'(voice_active), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_audio", int'(audio), 0);
    reset = 1'b0;
  endtask

  int  n, peak;
  bit  seen, found;

  initial begin
    snd_if.snd_wen = 1'b0;
    snd_if.w_param = '0;
    snd_if.w_index = '0;
    snd_if.w_val   = '0;
    #2;
    do_reset();

    // V0: period 3, vol 15, run until stopped
    wr(0, 0, 3); wr(1, 0, 15); wr(2, 0, 0); wr(3, 0, 1);
    chk("v0_active", int'(voice_active), 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin idle(1); if (audio == 8'd60) seen = 1; end
    chk("v0_level60", int'(seen), 1);

    // V1: period 1, vol 8, dur 2 -> expiry within 9..16 clocks of the start edge
    wr(0, 1, 1); wr(1, 1, 8); wr(2, 1, 2); wr(3, 1, 1);
    n = 0; found = 0;
    for (int i = 1; i <= 24; i++) begin
      idle(1);
      if (!found && !voice_active[1]) begin found = 1; n = i; end
    end
    chk("v1_expired", int'(found), 1);
    chk("v1_expiry_window", int'(n >= 9 && n <= 16), 1);

    // Out-of-range index ignored; stop beats start
    wr(3, 4, 3);
    chk("idx4_ignored", int'(voice_active[0]), 1);
    wr(3, 0, 3);
    chk("stop_wins", int'(voice_active[0]), 0);

    // All voices full volume, starts spaced by 4 edges so phases line up
    for (int v = 0; v < 4; v++) begin wr(0, v, 1); wr(1, v, 15); wr(2, v, 0); end
    for (int v = 0; v < 4; v++) begin wr(3, v, 1); if (v < 3) idle(3); end
    peak = 0;
    for (int i = 0; i < 12; i++) begin idle(1); if (int'(audio) > peak) peak = int'(audio); end
    chk("peak_240", peak, 240);

    // Mid-run reset; restart without a period write must stay silent
    do_reset();
    wr(1, 0, 15); wr(3, 0, 1);
    peak = 0;
    for (int i = 0; i < 20; i++) begin idle(1); if (int'(audio) > peak) peak = int'(audio); end
    chk("silent_after_reset", peak, 0);
    wr(3, 0, 2);

    // Control start on the expiry edge keeps the voice alive
    wr(0, 2, 2); wr(1, 2, 4); wr(2, 2, 1); wr(3, 2, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_act[2] && m_rem[2] == 1 && next_is_ms()) begin
        wr(3, 2, 1);
        chk("restart_on_expiry", int'(voice_active[2]), 1);
        found = 1;
      end else idle(1);
    end
    chk("expiry_edge_found", int'(found), 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin idle(1); if (!voice_active[2]) seen = 1; end
    chk("reloaded_then_expired", int'(seen), 1);

    // Randomized writes against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        int p, idx, val;
        p   = int'($urandom_range(0, 3));
        idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 2047)) : int'($urandom_range(0, 3));
        case (p)
          0: val = int'($urandom_range(0, 6));
          1: val = int'($urandom_range(0, 65535));
          2: val = int'($urandom_range(0, 3));
          default: val = int'($urandom_range(0, 3)) | (int'($urandom_range(0, 15)) << 2);
        endcase
        cyc(1, p, idx, val);
      end else begin
        idle(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
